apb_master: RTL and testbench

APB requester that turns single-beat read/write commands from a local controller into APB transfers and returns the read data or error to that controller. It is the initiator end of the peripheral bus whose completer side is the APB slave plus memory. The block has one outstanding transfer at a time, fully registered APB outputs, a bounded wait on `pready_i`, and a held response handshake.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master.sv | 129 ++++++++++++
 tb/tb_apb_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and default bus widths for the requester
// and completer sides of the peripheral bus.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_master_state_t;

  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master.sv
// APB requester: one outstanding single-beat transfer, registered
// APB outputs, bounded wait on pready and a held response.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_rnw_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT_CYCLES > 0) ?
    CW'(TIMEOUT_CYCLES) : '1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  apb_master_state_t state_q;
  apb_master_state_t state_d;

  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          done;
  logic          tmo;
  logic          tmo_hit;

  // the last waiting cycle is the one whose miss would saturate the count
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  assign cmd_ready_o = (state_q == IDLE);
  assign psel_o      = (state_q == SETUP) ||
                       (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign rsp_valid_o = (state_q == RESP);

  assign accept = cmd_valid_i && cmd_ready_o;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          state_d = RESP;
          done    = 1'b1;
        end else if (tmo_hit) begin
          state_d = RESP;
          tmo     = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !pready_i &&
                 cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
    end else if (accept) begin
      pwrite_o <= ~cmd_rnw_i;
      paddr_o  <= cmd_addr_i;
      pwdata_o <= cmd_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (done) begin
      rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
      rsp_err_o   <= 1'b0;
    end else if (tmo) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small APB memory
// completer for the back-to-back scenario.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rnw = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  logic        use_mem = 1'b0;
  logic        pready_drv = 1'b0;
  logic [31:0] prdata_drv = '0;
  logic [31:0] mem [0:1023];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign pready = use_mem ? (psel & penable) : pready_drv;
  assign prdata = use_mem ? mem[paddr] : prdata_drv;

  always @(posedge clk) begin
    if (use_mem && psel && penable && pwrite)
      mem[paddr] <= pwdata;
  end

  apb_master #(
    .ADDR_W(10),
    .DATA_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_rnw_i(cmd_rnw),
    .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .psel_o(psel),
    .penable_o(penable),
    .pwrite_o(pwrite),
    .paddr_o(paddr),
    .pwdata_o(pwdata),
    .prdata_i(prdata),
    .pready_i(pready)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic rnw, input logic [9:0] a,
                       input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    total++;
    if ({cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite}
        !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctl got %b exp 100000",
               {cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite});
    end
    total++;
    if ({paddr, pwdata, rsp_rdata} !== 74'd0) begin
      bad++;
      $display("FAIL reset_data got %h %h %h exp 0", paddr, pwdata, rsp_rdata);
    end
    reset = 1'b0;
    step;
    total++;
    if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
      bad++;
      $display("FAIL post_reset got %b exp 100", {cmd_ready, psel, rsp_valid});
    end
  endtask

  task automatic test_write_zero_wait;
    pready_drv = 1'b1;
    rsp_ready  = 1'b0;
    offer(1'b0, 10'h004, 32'hDEADBEEF);
    step;
    cmd_valid = 1'b0;
    total++;
    if ({psel, penable, pwrite, paddr, pwdata} !==
        {3'b101, 10'h004, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL wr_setup got %b%b%b %h %h", psel, penable, pwrite,
               paddr, pwdata);
    end
    step;
    total++;
    if ({psel, penable, pwrite, cmd_ready} !== 4'b1110) begin
      bad++;
      $display("FAIL wr_access got %b exp 1110",
               {psel, penable, pwrite, cmd_ready});
    end
    step;
    total++;
    if ({rsp_valid, rsp_err, psel, penable} !== 4'b1000 ||
        rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL wr_resp got %b %h exp 1000 0",
               {rsp_valid, rsp_err, psel, penable}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL wr_idle got %b exp 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_read_wait;
    pready_drv = 1'b0;
    prdata_drv = 32'hFFFF0000;
    offer(1'b1, 10'h00C, 32'h0);
    step;
    cmd_valid = 1'b0;
    step;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        pready_drv = 1'b1;
        prdata_drv = 32'h12345678;
      end
      total++;
      if ({psel, penable, pwrite, paddr} !== {3'b110, 10'h00C} ||
          rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rd_access%0d got %b %h", i,
                 {psel, penable, pwrite}, paddr);
      end
      step;
    end
    pready_drv = 1'b0;
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL rd_resp got %b %h exp 10 12345678",
               {rsp_valid, rsp_err}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    pready_drv = 1'b0;
    offer(1'b0, 10'h010, 32'h1111);
    step;
    cmd_valid = 1'b0;
    step;
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
        bad++;
        $display("FAIL to_wait%0d got %b exp 110", i,
                 {psel, penable, rsp_valid});
      end
      step;
    end
    total++;
    if ({rsp_valid, rsp_err, psel, penable} !== 4'b1100 ||
        rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL to_resp got %b %h exp 1100 0",
               {rsp_valid, rsp_err, psel, penable}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
  endtask

  task automatic test_ready_priority;
    pready_drv = 1'b0;
    prdata_drv = 32'h0BADF00D;
    offer(1'b1, 10'h020, 32'h0);
    step;
    cmd_valid = 1'b0;
    step;
    repeat (15) step;
    total++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      bad++;
      $display("FAIL pri_last got %b exp 110", {psel, penable, rsp_valid});
    end
    pready_drv = 1'b1;
    step;
    pready_drv = 1'b0;
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL pri_resp got %b %h exp 10 0badf00d",
               {rsp_valid, rsp_err}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_hold;
    pready_drv = 1'b1;
    prdata_drv = 32'hA5A50F0F;
    offer(1'b1, 10'h030, 32'h0);
    step;
    cmd_valid = 1'b0;
    step;
    step;
    prdata_drv = 32'h0;
    offer(1'b0, 10'h040, 32'h77665544);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, cmd_ready, psel} !== 3'b100 ||
          rsp_rdata !== 32'hA5A50F0F || rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d got %b %h exp 100 a5a50f0f", i,
                 {rsp_valid, cmd_ready, psel}, rsp_rdata);
      end
      step;
    end
    rsp_ready = 1'b1;
    step;
    total++;
    if ({cmd_ready, rsp_valid, psel} !== 3'b100) begin
      bad++;
      $display("FAIL hold_idle got %b exp 100", {cmd_ready, rsp_valid, psel});
    end
    step;
    cmd_valid = 1'b0;
    total++;
    if ({psel, penable, pwrite, paddr} !== {3'b101, 10'h040}) begin
      bad++;
      $display("FAIL hold_next got %b %h exp 101 040",
               {psel, penable, pwrite}, paddr);
    end
    step;
    step;
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL hold_wr_resp got %b %h exp 10 0",
               {rsp_valid, rsp_err}, rsp_rdata);
    end
    step;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    pready_drv = 1'b0;
    offer(1'b0, 10'h050, 32'h5A5A5A5A);
    step;
    cmd_valid = 1'b0;
    step;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({psel, penable} !== 2'b00) begin
      bad++;
      $display("FAIL rst_async got %b exp 00", {psel, penable});
    end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      total++;
      if ({rsp_valid, psel, cmd_ready} !== 3'b001) begin
        bad++;
        $display("FAIL rst_norsp%0d got %b exp 001", i,
                 {rsp_valid, psel, cmd_ready});
      end
    end
    pready_drv = 1'b1;
    offer(1'b0, 10'h060, 32'hC0FFEE00);
    step;
    cmd_valid = 1'b0;
    step;
    step;
    total++;
    if ({rsp_valid, rsp_err, pwrite, paddr} !== {3'b101, 10'h060}) begin
      bad++;
      $display("FAIL rst_fresh got %b %h exp 101 060",
               {rsp_valid, rsp_err, pwrite}, paddr);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    pready_drv = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc_wr;
    int acc_rd;
    int n;
    use_mem   = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) offer(1'b0, 10'h003, 32'hCAFEF00D);
      else        offer(1'b1, 10'h003, 32'h0);
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
        step;
        n++;
      end
      if (i == 0) acc_wr = cyc;
      else        acc_rd = cyc;
      step;
      cmd_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin
        step;
        n++;
      end
      total++;
      if (rsp_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_rsp%0d got %b exp 1", i, rsp_valid);
      end
      if (i == 1) begin
        total++;
        if (rsp_rdata !== 32'hCAFEF00D || rsp_err !== 1'b0) begin
          bad++;
          $display("FAIL b2b_data got %h %b exp cafef00d 0",
                   rsp_rdata, rsp_err);
        end
      end
      step;
    end
    total++;
    if (acc_rd - acc_wr < 4) begin
      bad++;
      $display("FAIL b2b_spacing got %0d exp >=4", acc_rd - acc_wr);
    end
    rsp_ready = 1'b0;
    use_mem   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    #1;
    test_reset;
    test_write_zero_wait;
    test_read_wait;
    test_timeout;
    test_ready_priority;
    test_rsp_hold;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
